muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the EX stage. It replaces the fixed 32-bit mul/div pair with one shared, width-generic datapath.
- Owns the HI/LO architectural registers and supports signed and unsigned MULT and DIV, plus MTHI/MTLO.
- Raises a stall request toward the pipeline controller while busy, and accepts a flush.
- One radix-2 iteration per cycle; shift-add for multiply, restoring for divide.

Parameters:
- DATA_W, 32, operand width, and the width of each of HI and LO; even, at least 8.
- CNT_W, $clog2(DATA_W), iteration counter width (derived, not to be overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  operation present in EX this cycle
- req_op  in  4  operation code (see package)
- src_a  in  DATA_W  rs operand (dividend / multiplicand / MTHI-MTLO data)
- src_b  in  DATA_W  rt operand (divisor / multiplier)
- flush  in  1  abort in-flight operation
- stallreq  out  1  hold the pipeline (combinational)
- busy  out  1  state != IDLE (registered)
- done  out  1  one-cycle pulse: HI/LO updated by a completed MULT/DIV
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, done=0, busy=0, stallreq=0, counter=0. Reset mid-operation discards all work.
- States: IDLE, CALC, SIGN, DONE.
- IDLE, with req_valid and a mul/div op:
  - stallreq=1 in the same cycle.
  - Latch |src_a| and |src_b| (raw values for unsigned ops), the op, and both sign bits.
  - Clear the accumulator and counter; go to CALC.
- CALC: one iteration per cycle; counter increments. At counter==DATA_W-1, go to SIGN. Exactly DATA_W CALC cycles.
- SIGN:
  - Apply sign correction.
  - MULT: negate the 2*DATA_W product if the signs differ.
  - DIV: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Write {hi,lo} at the end of this cycle (hi=remainder, lo=quotient for DIV). Go to DONE.
- DONE:
  - stallreq=0, done=1; new hi/lo are visible.
  - req_valid is ignored (it is the same, now-retiring instruction). Go to IDLE.
- stallreq is high for DATA_W+2 cycles (accept, CALC, SIGN) and low in DONE.
- Total latency from accept to done is DATA_W+2 cycles (34 at DATA_W=32).
- MTHI/MTLO in IDLE: no stall; hi (or lo) gets src_a at the clock edge and is visible the next cycle. done stays 0.
- MD_NOP, or an unknown op: ignored, no stall.
- Divide by zero: no exception; lo=all ones, hi=dividend (signed and unsigned).
- Signed overflow (MIN / -1): lo=MIN, hi=0.
- flush:
  - In any state other than IDLE: return to IDLE next edge; hi/lo unchanged; done not pulsed; stallreq forced 0 combinationally in that cycle.
  - flush in IDLE with req_valid: op not accepted, and MTHI/MTLO are suppressed.
  - flush has priority over everything except rst.
- Arithmetic: unsigned internally; accumulator and remainder are DATA_W+1 bits wide for carry/borrow.

Optional Feature:
- MULDIV_MACC_EN defined:
  - Ops MADD/MADDU/MSUB/MSUBU are accepted with the same latency.
  - In SIGN: {hi,lo} <= {hi,lo} ± the signed-corrected product, modulo 2^(2*DATA_W).
- Undefined: those encodings are treated as unknown ops (ignored, no stall). The ±accumulate adder is not synthesised.

Decomposition:
- Package muldiv_pkg:
  - Op codes: MD_NOP=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MADD=8, MD_MADDU=9, MD_MSUB=10, MD_MSUBU=11.
  - State enum md_state_t; the MD_OP_W=4 constant.
- Sub-module md_sign_fix: combinational abs/negate helper for operand conditioning and result correction, parametrised by DATA_W. It is instantiated for input and for output.

Test Plan:
- MULT a=0xFFFFFFFE, b=3: stallreq high exactly 34 cycles; done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands: lo=0x7FFFFFFC, hi=1.
- DIVU 7/0: lo=0xFFFFFFFF, hi=7. DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU 100/7 with flush at cycle 10: stallreq 0 that cycle; hi/lo keep old values; no done. MULTU 0xFFFFFFFF*0xFFFFFFFF next cycle: hi=0xFFFFFFFE, lo=0x00000001.
- MTHI 0x1234, then MTLO 0x5678 back-to-back: no stall; hi=0x1234, lo=0x5678 one cycle after each. Reset asserted mid-MULT: hi=lo=0, state IDLE.
- MULDIV_MACC_EN, hi:lo=0:5, MADD 3*4: lo=17. Then MSUB 0xFFFFFFFF*1: lo=18. Without the macro, MADD is ignored: no stall, hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and op classification helpers.
package muldiv_pkg;

  localparam int unsigned MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NOP   = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd9;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd10;
  localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd11;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_SIGN,
    MD_DONE
  } md_state_t;

  function automatic logic md_is_signed(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_macc(input logic [MD_OP_W-1:0] op);
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  function automatic logic md_is_msub(input logic [MD_OP_W-1:0] op);
    return (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Combinational conditional two's-complement negate; gives |x| on the way in
// and restores the sign of products, quotients and remainders on the way out.
module md_sign_fix #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] val,
  input  logic              neg,
  output logic [DATA_W-1:0] res
);

  always_comb begin
    res = neg ? (~val + 1'b1) : val;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO.
// Define MULDIV_MACC_EN to accept MADD/MADDU/MSUB/MSUBU.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [MD_OP_W-1:0] req_op,
  input  logic [DATA_W-1:0]  src_a,
  input  logic [DATA_W-1:0]  src_b,
  input  logic               flush,
  output logic               stallreq,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  md_state_t          state;
  logic [MD_OP_W-1:0] op_q;
  logic               sign_a;
  logic               sign_b;
  logic               div_zero;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W:0]    acc;
  logic [DATA_W-1:0]  mq;
  logic [DATA_W-1:0]  dvs;

  logic               op_ok;
  logic               accept;
  logic               req_signed;
  logic               neg_a_in;
  logic               neg_b_in;
  logic [DATA_W-1:0]  abs_a;
  logic [DATA_W-1:0]  abs_b;

  logic [DATA_W:0]    mul_sum;
  logic [DATA_W:0]    div_shift;
  logic [DATA_W:0]    div_diff;
  logic               q_bit;
  logic [DATA_W:0]    acc_nx;
  logic [DATA_W-1:0]  mq_nx;

  logic [2*DATA_W-1:0] prod_raw;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   lo_div;
  logic [2*DATA_W-1:0] hilo_nx;

  always_comb begin
    op_ok = (req_op == MD_MULT) || (req_op == MD_MULTU) ||
            (req_op == MD_DIV)  || (req_op == MD_DIVU);
`ifdef MULDIV_MACC_EN
    op_ok = op_ok || md_is_macc(req_op);
`endif
  end

  assign accept     = (state == MD_IDLE) && req_valid && op_ok && !flush;
  assign stallreq   = !flush && (accept || (state == MD_CALC) || (state == MD_SIGN));
  assign req_signed = md_is_signed(req_op);
  assign neg_a_in   = req_signed & src_a[DATA_W-1];
  assign neg_b_in   = req_signed & src_b[DATA_W-1];

  md_sign_fix #(.DATA_W(DATA_W)) u_abs_a (.val(src_a), .neg(neg_a_in), .res(abs_a));
  md_sign_fix #(.DATA_W(DATA_W)) u_abs_b (.val(src_b), .neg(neg_b_in), .res(abs_b));

  // mq holds |a| in both modes: the multiplier for MULT (shifted out from the
  // bottom) and the dividend for DIV (shifted out from the top, quotient in).
  always_comb begin
    mul_sum   = acc + {1'b0, (mq[0] ? dvs : '0)};
    div_shift = {acc[DATA_W-1:0], mq[DATA_W-1]};
    div_diff  = div_shift - {1'b0, dvs};
    q_bit     = ~div_diff[DATA_W];
    if (md_is_div(op_q)) begin
      acc_nx = q_bit ? div_diff : div_shift;
      mq_nx  = {mq[DATA_W-2:0], q_bit};
    end else begin
      acc_nx = {1'b0, mul_sum[DATA_W:1]};
      mq_nx  = {mul_sum[0], mq[DATA_W-1:1]};
    end
  end

  assign prod_raw = {acc[DATA_W-1:0], mq};

  md_sign_fix #(.DATA_W(2*DATA_W)) u_fix_prod (
    .val(prod_raw), .neg(sign_a ^ sign_b), .res(prod_fix));
  md_sign_fix #(.DATA_W(DATA_W)) u_fix_quo (
    .val(mq), .neg(sign_a ^ sign_b), .res(quo_fix));
  md_sign_fix #(.DATA_W(DATA_W)) u_fix_rem (
    .val(acc[DATA_W-1:0]), .neg(sign_a), .res(rem_fix));

  // Divide by zero leaves |dividend| as remainder, so hi comes out as the raw
  // dividend; only the quotient needs overriding.
  always_comb begin
    lo_div = div_zero ? '1 : quo_fix;
    if (md_is_div(op_q)) begin
      hilo_nx = {rem_fix, lo_div};
    end else begin
      hilo_nx = prod_fix;
    end
`ifdef MULDIV_MACC_EN
    if (md_is_macc(op_q)) begin
      hilo_nx = md_is_msub(op_q) ? ({hi, lo} - prod_fix) : ({hi, lo} + prod_fix);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MD_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      op_q     <= MD_NOP;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      dvs      <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= MD_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          MD_IDLE: begin
            if (accept) begin
              op_q     <= req_op;
              sign_a   <= neg_a_in;
              sign_b   <= neg_b_in;
              div_zero <= (src_b == '0);
              mq       <= abs_a;
              dvs      <= abs_b;
              acc      <= '0;
              cnt      <= '0;
              state    <= MD_CALC;
              busy     <= 1'b1;
            end else if (req_valid && (req_op == MD_MTHI)) begin
              hi <= src_a;
            end else if (req_valid && (req_op == MD_MTLO)) begin
              lo <= src_a;
            end
          end
          MD_CALC: begin
            acc <= acc_nx;
            mq  <= mq_nx;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= MD_SIGN;
            end
          end
          MD_SIGN: begin
            {hi, lo} <= hilo_nx;
            done     <= 1'b1;
            state    <= MD_DONE;
          end
          MD_DONE: begin
            state <= MD_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= MD_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
